// File: rtl/pcs_transmit_code_group.sv
// 8B/10B transmit code-group stage: one code group per clk from the ordered-set selector, running disparity tracked.
// Latency: tx_o_set/txd sampled at a rising edge, code group registered on that edge. Optional macro PCS_TX_ODD_FILL_EN.
// Backpressure: tx_oset_indicate (combinational) tells upstream its selector was consumed; power_on=0 freezes everything.
module pcs_transmit_code_group #(
    parameter logic RD_INIT   = 1'b0,
    parameter logic EVEN_INIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic [7:0] tx_o_set,
    input  logic [7:0] txd,
    output logic [9:0] tx_code_group,
    output logic       tx_oset_indicate,
    output logic       tx_even
);

    localparam logic [7:0] OS_I   = 8'hBC;
    localparam logic [7:0] OS_S   = 8'hFB;
    localparam logic [7:0] OS_T   = 8'hFD;
    localparam logic [7:0] OS_R   = 8'hF7;
    localparam logic [7:0] OS_D   = 8'hFF;
    localparam logic [7:0] K30_7  = 8'hFE;
    localparam logic [7:0] D5_6   = 8'hC5;
    localparam logic [7:0] D16_2  = 8'h50;

    typedef enum logic {GEN, IDLE_2ND} state_t;

    state_t state, state_nxt;
    logic   rd, idle_sel, idle_sel_nxt, fill;
    logic   enc_k;
    logic [7:0]  enc_byte;
    logic [10:0] enc;

    // RD- forms; RD+ form is the complement for unbalanced codes and D7
    function automatic logic [5:0] six_b(input logic [4:0] x);
        case (x)
            5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
            5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
            5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
            5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
            5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
            5'd10: return 6'b010101;  5'd11: return 6'b110100;
            5'd12: return 6'b001101;  5'd13: return 6'b101100;
            5'd14: return 6'b011100;  5'd15: return 6'b010111;
            5'd16: return 6'b011011;  5'd17: return 6'b100011;
            5'd18: return 6'b010011;  5'd19: return 6'b110010;
            5'd20: return 6'b001011;  5'd21: return 6'b101010;
            5'd22: return 6'b011010;  5'd23: return 6'b111010;
            5'd24: return 6'b110011;  5'd25: return 6'b100110;
            5'd26: return 6'b010110;  5'd27: return 6'b110110;
            5'd28: return 6'b001110;  5'd29: return 6'b101110;
            5'd30: return 6'b011110;  default: return 6'b101011;
        endcase
    endfunction

    function automatic logic [3:0] four_b(input logic [2:0] y);
        case (y)
            3'd0: return 4'b1011;  3'd1: return 4'b1001;
            3'd2: return 4'b0101;  3'd3: return 4'b1100;
            3'd4: return 4'b1101;  3'd5: return 4'b1010;
            3'd6: return 4'b0110;  default: return 4'b1110;
        endcase
    endfunction

    // returns {rd_out, abcdei, fghj}
    function automatic logic [10:0] encode(input logic k, input logic [7:0] b, input logic rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd_mid, alt;
        x  = b[4:0];
        y  = b[7:5];
        c6 = (k && x == 5'd28) ? 6'b001111 : six_b(x);
        if (rd_in && ($countones(c6) != 3 || x == 5'd7))
            c6 = ~c6;
        rd_mid = rd_in ^ ($countones(c6) != 3);
        alt = (y == 3'd7) && (k ||
              (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        c4 = alt ? 4'b0111 : four_b(y);
        if (rd_mid && ($countones(c4) != 2 || y == 3'd3))
            c4 = ~c4;
        // K28 balanced columns run opposite to the data table
        if (k && x == 5'd28 && !rd_mid && $countones(c4) == 2 && y != 3'd3)
            c4 = ~c4;
        return {rd_mid ^ ($countones(c4) != 2), c6, c4};
    endfunction

    always_comb begin
        state_nxt        = state;
        idle_sel_nxt     = idle_sel;
        tx_oset_indicate = 1'b0;
        enc_k            = 1'b1;
        enc_byte         = K30_7;
`ifdef PCS_TX_ODD_FILL_EN
        fill = !tx_even;
`else
        fill = 1'b0;
`endif
        case (state)
            GEN: begin
                tx_oset_indicate = 1'b1;
                case (tx_o_set)
                    OS_I: begin
                        tx_oset_indicate = 1'b0;
                        if (fill) begin
                            enc_byte = OS_R;
                        end else begin
                            enc_byte     = OS_I;
                            idle_sel_nxt = rd;
                            state_nxt    = IDLE_2ND;
                        end
                    end
                    OS_S, OS_T, OS_R: enc_byte = tx_o_set;
                    OS_D: begin
                        enc_k    = 1'b0;
                        enc_byte = txd;
                    end
                    default: enc_byte = K30_7;
                endcase
            end
            default: begin
                tx_oset_indicate = 1'b1;
                enc_k            = 1'b0;
                enc_byte         = idle_sel ? D5_6 : D16_2;
                state_nxt        = GEN;
            end
        endcase
        if (!power_on)
            tx_oset_indicate = 1'b0;
        enc = encode(enc_k, enc_byte, rd);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= GEN;
            rd            <= RD_INIT;
            idle_sel      <= 1'b0;
            tx_even       <= EVEN_INIT;
            tx_code_group <= 10'h000;
        end else if (power_on) begin
            state         <= state_nxt;
            rd            <= enc[10];
            idle_sel      <= idle_sel_nxt;
            tx_even       <= ~tx_even;
            tx_code_group <= enc[9:0];
        end
    end

endmodule

// File: tb/tb_pcs_transmit_code_group.sv
// Bench for pcs_transmit_code_group: directed scenarios plus random traffic against a table-driven 8B/10B reference.
module tb_pcs_transmit_code_group;

    logic       clk = 1'b0;
    logic       rst, power_on;
    logic [7:0] tx_o_set, txd;
    logic [9:0] tx_code_group;
    logic       tx_oset_indicate, tx_even;

    pcs_transmit_code_group dut (
        .clk(clk), .rst(rst), .power_on(power_on), .tx_o_set(tx_o_set), .txd(txd),
        .tx_code_group(tx_code_group), .tx_oset_indicate(tx_oset_indicate), .tx_even(tx_even)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    logic       m_rd, m_even, m_second, m_sel, exp_ind;
    logic [9:0] m_code;
    logic       obs_ind, obs_even;
    logic [9:0] obs_code;

    // {RD- column, RD+ column}
    function automatic logic [11:0] six_pair(input logic [4:0] x);
        case (x)
            5'd0:  return {6'b100111, 6'b011000};  5'd1:  return {6'b011101, 6'b100010};
            5'd2:  return {6'b101101, 6'b010010};  5'd3:  return {6'b110001, 6'b110001};
            5'd4:  return {6'b110101, 6'b001010};  5'd5:  return {6'b101001, 6'b101001};
            5'd6:  return {6'b011001, 6'b011001};  5'd7:  return {6'b111000, 6'b000111};
            5'd8:  return {6'b111001, 6'b000110};  5'd9:  return {6'b100101, 6'b100101};
            5'd10: return {6'b010101, 6'b010101};  5'd11: return {6'b110100, 6'b110100};
            5'd12: return {6'b001101, 6'b001101};  5'd13: return {6'b101100, 6'b101100};
            5'd14: return {6'b011100, 6'b011100};  5'd15: return {6'b010111, 6'b101000};
            5'd16: return {6'b011011, 6'b100100};  5'd17: return {6'b100011, 6'b100011};
            5'd18: return {6'b010011, 6'b010011};  5'd19: return {6'b110010, 6'b110010};
            5'd20: return {6'b001011, 6'b001011};  5'd21: return {6'b101010, 6'b101010};
            5'd22: return {6'b011010, 6'b011010};  5'd23: return {6'b111010, 6'b000101};
            5'd24: return {6'b110011, 6'b001100};  5'd25: return {6'b100110, 6'b100110};
            5'd26: return {6'b010110, 6'b010110};  5'd27: return {6'b110110, 6'b001001};
            5'd28: return {6'b001110, 6'b001110};  5'd29: return {6'b101110, 6'b010001};
            5'd30: return {6'b011110, 6'b100001};  default: return {6'b101011, 6'b010100};
        endcase
    endfunction

    function automatic logic [7:0] four_pair(input logic [2:0] y);
        case (y)
            3'd0: return {4'b1011, 4'b0100};  3'd1: return {4'b1001, 4'b1001};
            3'd2: return {4'b0101, 4'b0101};  3'd3: return {4'b1100, 4'b0011};
            3'd4: return {4'b1101, 4'b0010};  3'd5: return {4'b1010, 4'b1010};
            3'd6: return {4'b0110, 4'b0110};  default: return {4'b1110, 4'b0001};
        endcase
    endfunction

    // K symbols used here: K28.5 and K23/27/29/30.7
    task automatic model_encode(input logic k, input logic [7:0] b);
        logic [4:0]  x;
        logic [2:0]  y;
        logic [11:0] p6;
        logic [7:0]  p4;
        logic [5:0]  c6;
        logic [3:0]  c4;
        x  = b[4:0];
        y  = b[7:5];
        p6 = (k && x == 5'd28) ? {6'b001111, 6'b110000} : six_pair(x);
        c6 = m_rd ? p6[5:0] : p6[11:6];
        if ($countones(c6) != 3) m_rd = ~m_rd;
        if (k && y == 3'd7)
            p4 = {4'b0111, 4'b1000};
        else if (k)
            p4 = {4'b0101, 4'b1010};
        else if (y == 3'd7 && ((!m_rd && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                               ( m_rd && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
            p4 = {4'b0111, 4'b1000};
        else
            p4 = four_pair(y);
        c4 = m_rd ? p4[3:0] : p4[7:4];
        if ($countones(c4) != 2) m_rd = ~m_rd;
        m_code = {c6, c4};
    endtask

    task automatic model_reset();
        m_rd = 1'b0; m_even = 1'b1; m_second = 1'b0; m_sel = 1'b0; m_code = 10'h000;
    endtask

    task automatic model_step(input logic pwr, input logic [7:0] os, input logic [7:0] d);
        logic fill;
        exp_ind = 1'b0;
        if (pwr) begin
            if (m_second) begin
                model_encode(1'b0, m_sel ? 8'hC5 : 8'h50);
                exp_ind  = 1'b1;
                m_second = 1'b0;
            end else if (os == 8'hBC) begin
`ifdef PCS_TX_ODD_FILL_EN
                fill = !m_even;
`else
                fill = 1'b0;
`endif
                if (fill) begin
                    model_encode(1'b1, 8'hF7);
                end else begin
                    m_sel = m_rd;
                    model_encode(1'b1, 8'hBC);
                    m_second = 1'b1;
                end
            end else if (os == 8'hFB || os == 8'hFD || os == 8'hF7) begin
                model_encode(1'b1, os);
                exp_ind = 1'b1;
            end else if (os == 8'hFF) begin
                model_encode(1'b0, d);
                exp_ind = 1'b1;
            end else begin
                model_encode(1'b1, 8'hFE);
                exp_ind = 1'b1;
            end
            m_even = ~m_even;
        end
    endtask

    // one clock: drive at negedge, sample indicate before the edge and registers after it
    task automatic drive(input logic pwr, input logic [7:0] os, input logic [7:0] d);
        @(negedge clk);
        power_on = pwr; tx_o_set = os; txd = d;
        #1;
        obs_ind = tx_oset_indicate;
        model_step(pwr, os, d);
        @(posedge clk);
        #1;
        obs_code = tx_code_group;
        obs_even = tx_even;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (tx_code_group !== 10'h000) begin n_fail++; $display("FAIL reset_code: got %b expected %b", tx_code_group, 10'h000); end
        n_checks++; if (tx_even !== 1'b1) begin n_fail++; $display("FAIL reset_even: got %b expected 1", tx_even); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (tx_code_group !== 10'h000 || tx_even !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b/%b expected %b/1", tx_code_group, tx_even, 10'h000); end
    endtask

    task automatic test_idle();
        logic [9:0] codes [4] = '{10'b0011111010, 10'b1001000101, 10'b0011111010, 10'b1001000101};
        logic       inds  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       evens [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hBC, 8'h00);
            n_checks++; if (obs_code !== codes[i]) begin n_fail++; $display("FAIL idle_code[%0d]: got %b expected %b", i, obs_code, codes[i]); end
            n_checks++; if (obs_ind !== inds[i]) begin n_fail++; $display("FAIL idle_ind[%0d]: got %b expected %b", i, obs_ind, inds[i]); end
            n_checks++; if (obs_even !== evens[i]) begin n_fail++; $display("FAIL idle_even[%0d]: got %b expected %b", i, obs_even, evens[i]); end
        end
    endtask

    task automatic test_data_zero();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hFF, 8'h00);
            n_checks++; if (obs_code !== 10'b1001110100) begin n_fail++; $display("FAIL d0_code[%0d]: got %b expected %b", i, obs_code, 10'b1001110100); end
            n_checks++; if (obs_ind !== 1'b1) begin n_fail++; $display("FAIL d0_ind[%0d]: got %b expected 1", i, obs_ind); end
        end
    endtask

    task automatic test_invalid();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h55, 8'($urandom));
            n_checks++; if (obs_code !== 10'b0111101000) begin n_fail++; $display("FAIL invalid_code[%0d]: got %b expected %b", i, obs_code, 10'b0111101000); end
            n_checks++; if (obs_ind !== 1'b1) begin n_fail++; $display("FAIL invalid_ind[%0d]: got %b expected 1", i, obs_ind); end
        end
    endtask

    task automatic test_ordered_sets();
        logic [7:0] os [6] = '{8'hBC, 8'hBC, 8'hFB, 8'hFF, 8'hBC, 8'hBC};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, os[i], 8'h03);
            n_checks++; if (obs_code !== m_code) begin n_fail++; $display("FAIL oset_code[%0d]: got %b expected %b", i, obs_code, m_code); end
            n_checks++; if (obs_ind !== exp_ind) begin n_fail++; $display("FAIL oset_ind[%0d]: got %b expected %b", i, obs_ind, exp_ind); end
        end
        n_checks++; if (obs_code !== 10'b1010010110) begin n_fail++; $display("FAIL i1_code: got %b expected %b", obs_code, 10'b1010010110); end
    endtask

    task automatic test_fill();
        logic [7:0] os [9] = '{8'hFB, 8'hFF, 8'hFF, 8'hFD, 8'hF7, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, os[i], 8'($urandom));
            n_checks++; if (obs_code !== m_code) begin n_fail++; $display("FAIL fill_code[%0d]: got %b expected %b", i, obs_code, m_code); end
            n_checks++; if (obs_ind !== exp_ind) begin n_fail++; $display("FAIL fill_ind[%0d]: got %b expected %b", i, obs_ind, exp_ind); end
            n_checks++; if (obs_even !== m_even) begin n_fail++; $display("FAIL fill_even[%0d]: got %b expected %b", i, obs_even, m_even); end
        end
    endtask

    task automatic test_power_off();
        drive(1'b1, 8'hBC, 8'h00);
        for (int i = 0; i < 6; i++) begin
            drive(i < 4 ? 1'b0 : 1'b1, 8'($urandom), 8'($urandom));
            n_checks++; if (obs_code !== m_code) begin n_fail++; $display("FAIL pwr_code[%0d]: got %b expected %b", i, obs_code, m_code); end
            n_checks++; if (obs_ind !== exp_ind) begin n_fail++; $display("FAIL pwr_ind[%0d]: got %b expected %b", i, obs_ind, exp_ind); end
            n_checks++; if (obs_even !== m_even) begin n_fail++; $display("FAIL pwr_even[%0d]: got %b expected %b", i, obs_even, m_even); end
        end
    endtask

    task automatic test_random();
        logic [7:0] os;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0, 7:    os = 8'hBC;
                1:       os = 8'hFB;
                2:       os = 8'hFD;
                3:       os = 8'hF7;
                6:       os = 8'($urandom);
                default: os = 8'hFF;
            endcase
            drive($urandom_range(0, 9) != 0, os, 8'($urandom));
            n_checks++; if (obs_code !== m_code) begin n_fail++; $display("FAIL rand_code[%0d]: got %b expected %b", i, obs_code, m_code); end
            n_checks++; if (obs_ind !== exp_ind) begin n_fail++; $display("FAIL rand_ind[%0d]: got %b expected %b", i, obs_ind, exp_ind); end
            n_checks++; if (obs_even !== m_even) begin n_fail++; $display("FAIL rand_even[%0d]: got %b expected %b", i, obs_even, m_even); end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'hFB, 8'h00);
        drive(1'b1, 8'hBC, 8'h00);
        @(negedge clk); #2;
        rst = 1'b0; power_on = 1'b0;
        #1;
        n_checks++; if (tx_code_group !== 10'h000) begin n_fail++; $display("FAIL arst_code: got %b expected %b", tx_code_group, 10'h000); end
        n_checks++; if (tx_even !== 1'b1) begin n_fail++; $display("FAIL arst_even: got %b expected 1", tx_even); end
        model_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 8'hBC, 8'h00);
        n_checks++; if (obs_code !== 10'b0011111010) begin n_fail++; $display("FAIL arst_first: got %b expected %b", obs_code, 10'b0011111010); end
        drive(1'b1, 8'hBC, 8'h00);
        n_checks++; if (obs_code !== m_code) begin n_fail++; $display("FAIL arst_second: got %b expected %b", obs_code, m_code); end
    endtask

    initial begin
        rst = 1'b0; power_on = 1'b0; tx_o_set = 8'hBC; txd = 8'h00;
        model_reset();
        test_reset();
        test_idle();
        test_data_zero();
        test_invalid();
        test_ordered_sets();
        test_fill();
        test_power_off();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
